subword_access: RTL and testbench

Sub-word memory access unit between the datapath's memory stage and the word-addressed data cache port. It is the narrowing counterpart of immediate extension, handling byte, halfword and word loads and stores.
- Loads: fetches the aligned word, selects the addressed byte or halfword lane, and sign- or zero-extends it to 32 bits.
- Sub-word stores: performs a read-modify-write, merging the new lane into the fetched word, and writes it back.

---
 rtl/subword_access.sv | 203 ++++++++++++++++++++
 tb/tb_subword_access.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/subword_access.sv
// Sub-word load/store unit between the memory stage and a word-addressed data cache port.
// Latency: load / word store N+1 cycles, sub-word store N1+N2+1, rejected request 1 cycle.
// Backpressure: requests are sampled only in IDLE (busy=0); cache stalls by withholding dhit.
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   req_ren / req_wen     load / store request, sampled in IDLE only
//   req_size              00 byte, 01 halfword, 10 word, 11 illegal
//   req_signed            sign-extend sub-word loads
//   req_addr, req_wdata   byte address, right-justified store data
//   req_rdata             load result, valid with req_done
//   req_done, req_err     completion pulse, error pulse (with req_done)
//   busy                  high whenever not IDLE
//   dREN, dWEN, daddr     cache read/write enables, word-aligned address
//   dstore, dload, dhit   cache write data, read data, access-complete strobe
module subword_access (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_ren,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] req_rdata,
  output logic        req_done,
  output logic        req_err,
  output logic        busy,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dhit
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t      state_q,  state_d;
  logic [31:0] addr_q,   addr_d;
  logic [1:0]  size_q,   size_d;
  logic        sgn_q,    sgn_d;
  logic        store_q,  store_d;
  // Only the low halfword is ever merged; full-word stores go straight to dstore.
  logic [15:0] wdata_q,  wdata_d;
  logic [31:0] dstore_q, dstore_d;
  logic [31:0] rdata_q,  rdata_d;

  logic        req_bad;

  // Big-endian lane select followed by sign/zero extension.
  function automatic logic [31:0] extract_lane(
    input logic [31:0] word,
    input logic [1:0]  sz,
    input logic [1:0]  off,
    input logic        sx
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (sz)
      SZ_BYTE: r = {{24{sx & b[7]}}, b};
      SZ_HALF: r = {{16{sx & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the fetched word.
  function automatic logic [31:0] merge_lane(
    input logic [31:0] word,
    input logic [1:0]  sz,
    input logic [1:0]  off,
    input logic [15:0] wd
  );
    logic [31:0] r;
    r = word;
    if (sz == SZ_BYTE) begin
      case (off)
        2'd0:    r[31:24] = wd[7:0];
        2'd1:    r[23:16] = wd[7:0];
        2'd2:    r[15:8]  = wd[7:0];
        default: r[7:0]   = wd[7:0];
      endcase
    end else if (sz == SZ_HALF) begin
      if (off[1]) r[15:0]  = wd;
      else        r[31:16] = wd;
    end
    return r;
  endfunction

  // Rejected requests never touch the cache.
  always_comb begin
    req_bad = 1'b0;
    if (req_ren && req_wen)                               req_bad = 1'b1;
    if (req_size == 2'b11)                                req_bad = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])               req_bad = 1'b1;
    if (req_size == SZ_WORD && (req_addr[1:0] != 2'b00))  req_bad = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    store_d  = store_q;
    wdata_d  = wdata_q;
    dstore_d = dstore_q;
    rdata_d  = rdata_q;

    case (state_q)
      IDLE: begin
        if (req_ren || req_wen) begin
          addr_d  = req_addr;
          size_d  = req_size;
          sgn_d   = req_signed;
          store_d = req_wen;
          wdata_d = req_wdata[15:0];
          if (req_bad) begin
            state_d = ERR;
          end else if (req_wen && req_size == SZ_WORD) begin
            // Full-word store needs no fetch.
            dstore_d = req_wdata;
            state_d  = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end

      READ: begin
        if (dhit) begin
          if (store_q) begin
            dstore_d = merge_lane(dload, size_q, addr_q[1:0], wdata_q);
            state_d  = WRITE;
          end else begin
            rdata_d = extract_lane(dload, size_q, addr_q[1:0], sgn_q);
            state_d = DONE;
          end
        end
      end

      WRITE: begin
        if (dhit) state_d = DONE;
      end

      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      sgn_q    <= 1'b0;
      store_q  <= 1'b0;
      wdata_q  <= '0;
      dstore_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      store_q  <= store_d;
      wdata_q  <= wdata_d;
      dstore_q <= dstore_d;
      rdata_q  <= rdata_d;
    end
  end

  // Moore decode of the registered state; reset forces all of these low at once.
  assign dREN      = (state_q == READ);
  assign dWEN      = (state_q == WRITE);
  assign req_done  = (state_q == DONE) || (state_q == ERR);
  assign req_err   = (state_q == ERR);
  assign busy      = (state_q != IDLE);
  assign daddr     = {addr_q[31:2], 2'b00};
  assign dstore    = dstore_q;
  // Last load result is kept across stores and errors, but reads as zero during ERR.
  assign req_rdata = (state_q == ERR) ? 32'h0 : rdata_q;

endmodule

// File: tb/tb_subword_access.sv
// Directed self-checking bench for subword_access.
// Latency: measures req_done cycle relative to the acceptance cycle (cycle 0).
// Backpressure: cache model withholds dhit for a programmable number of cycles per access.
module tb_subword_access;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_ren, req_wen, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] req_rdata;
  logic        req_done, req_err, busy, dREN, dWEN;
  logic [31:0] daddr, dstore, dload;
  logic        dhit;

  subword_access dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_ren    (req_ren),
    .req_wen    (req_wen),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rdata  (req_rdata),
    .req_done   (req_done),
    .req_err    (req_err),
    .busy       (busy),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .daddr      (daddr),
    .dstore     (dstore),
    .dload      (dload),
    .dhit       (dhit)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  int          r_done_cyc, r_dren, r_dwen;
  logic [31:0] r_store, r_rdata;
  logic        r_err, r_overlap, r_daddr_bad, r_idle;
  logic        seen_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request in the current (IDLE) cycle, play the cache until req_done,
  // then step one more cycle into IDLE so the next call is back-to-back.
  task automatic run(input logic ren, input logic wen, input logic [1:0] size,
                     input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                     input int dly, input logic [31:0] old);
    int          cyc;
    int          wait_cnt;
    logic [31:0] exp_daddr;
    cyc = 0;
    wait_cnt = 0;
    exp_daddr = {addr[31:2], 2'b00};
    r_done_cyc = -1; r_dren = 0; r_dwen = 0; r_store = '0; r_rdata = '0;
    r_err = 1'b0; r_overlap = 1'b0; r_daddr_bad = 1'b0; r_idle = 1'b0;
    req_ren = ren; req_wen = wen; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; dhit = 1'b0; dload = ~old;
    while (r_done_cyc < 0 && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      // Scrub the request so the DUT must rely on its latched copy.
      req_ren = 1'b0; req_wen = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0;
      dhit = 1'b0; dload = ~old;
      if (dREN && dWEN) r_overlap = 1'b1;
      if (dREN) r_dren++;
      if (dWEN) begin r_dwen++; r_store = dstore; end
      if ((dREN || dWEN) && daddr !== exp_daddr) r_daddr_bad = 1'b1;
      if (dREN || dWEN) begin
        wait_cnt++;
        if (wait_cnt >= dly) begin
          dhit = 1'b1; dload = old; wait_cnt = 0;
        end
      end
      if (req_done) begin
        r_done_cyc = cyc; r_err = req_err; r_rdata = req_rdata;
      end
    end
    dhit = 1'b0;
    @(posedge CLK); #1;
    r_idle = !busy;
  endtask

  initial begin
    RST = 1'b1;
    req_ren = 1'b0; req_wen = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; dload = '0; dhit = 1'b0;
    #12;
    chk("rst_outputs", {28'h0, req_done, req_err, busy, dREN | dWEN}, 32'h0);
    chk("rst_rdata",   req_rdata, 32'h0);
    chk("rst_daddr",   daddr,     32'h0);
    chk("rst_dstore",  dstore,    32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // dhit with no access in flight must not start anything.
    dhit = 1'b1; dload = 32'hFFFF_FFFF;
    @(posedge CLK); #1;
    dhit = 1'b0;
    chk("stray_dhit_busy", {31'h0, busy}, 32'h0);

    // LB signed, offset 1
    run(1, 0, 2'b00, 1, 32'h0000_1001, 32'h0, 1, 32'h12F4_5678);
    chk("lb_rdata", r_rdata, 32'hFFFF_FFF4);
    chk("lb_lat",   r_done_cyc, 32'd2);
    chk("lb_dren",  r_dren, 32'd1);
    chk("lb_idle",  {31'h0, r_idle}, 32'h1);
    // LBU same
    run(1, 0, 2'b00, 0, 32'h0000_1001, 32'h0, 1, 32'h12F4_5678);
    chk("lbu_rdata", r_rdata, 32'h0000_00F4);
    // LB offset 0, positive byte
    run(1, 0, 2'b00, 1, 32'h0000_1000, 32'h0, 1, 32'h12F4_5678);
    chk("lb0_rdata", r_rdata, 32'h0000_0012);
    // LHU / LH offset 2
    run(1, 0, 2'b01, 0, 32'h0000_2002, 32'h0, 1, 32'h1234_ABCD);
    chk("lhu_rdata", r_rdata, 32'h0000_ABCD);
    run(1, 0, 2'b01, 1, 32'h0000_2002, 32'h0, 1, 32'h1234_ABCD);
    chk("lh_rdata", r_rdata, 32'hFFFF_ABCD);
    // LH offset 0
    run(1, 0, 2'b01, 1, 32'h0000_2000, 32'h0, 2, 32'h8001_FFFF);
    chk("lh0_rdata", r_rdata, 32'hFFFF_8001);
    chk("lh0_lat",   r_done_cyc, 32'd3);
    // LW, signed flag must not matter
    run(1, 0, 2'b10, 1, 32'h0000_2000, 32'h0, 1, 32'h1234_ABCD);
    chk("lw_rdata", r_rdata, 32'h1234_ABCD);
    chk("lw_daddr_ok", {31'h0, r_daddr_bad}, 32'h0);

    // SB offset 3 with 3-cycle hits on both accesses
    run(0, 1, 2'b00, 0, 32'h0000_3003, 32'h0000_00AA, 3, 32'h1122_3344);
    chk("sb_dren",   r_dren, 32'd3);
    chk("sb_dwen",   r_dwen, 32'd3);
    chk("sb_dstore", r_store, 32'h1122_33AA);
    chk("sb_lat",    r_done_cyc, 32'd7);
    chk("sb_overlap", {31'h0, r_overlap}, 32'h0);
    chk("sb_daddr_ok", {31'h0, r_daddr_bad}, 32'h0);
    // SB offset 0
    run(0, 1, 2'b00, 0, 32'h0000_6000, 32'h0000_0055, 1, 32'h1122_3344);
    chk("sb0_dstore", r_store, 32'h5522_3344);
    // SW: no read
    run(0, 1, 2'b10, 0, 32'h0000_4000, 32'hDEAD_BEEF, 1, 32'h0);
    chk("sw_dren",   r_dren, 32'd0);
    chk("sw_dwen",   r_dwen, 32'd1);
    chk("sw_dstore", r_store, 32'hDEAD_BEEF);
    chk("sw_lat",    r_done_cyc, 32'd2);
    // SH offset 0
    run(0, 1, 2'b01, 0, 32'h0000_4000, 32'h0000_BEEF, 1, 32'h0102_0304);
    chk("sh_dstore", r_store, 32'hBEEF_0304);
    chk("sh_lat",    r_done_cyc, 32'd3);

    // Rejected requests
    run(0, 1, 2'b01, 0, 32'h0000_5001, 32'h0000_1234, 1, 32'h0);
    chk("err_sh_lat", r_done_cyc, 32'd1);
    chk("err_sh",     {r_rdata[30:0], r_err}, 32'h1);
    chk("err_sh_acc", r_dren + r_dwen, 32'd0);
    run(1, 0, 2'b10, 0, 32'h0000_5002, 32'h0, 1, 32'h0);
    chk("err_lw",     {r_rdata[30:0], r_err}, 32'h1);
    chk("err_lw_rd0", r_rdata, 32'h0);
    chk("err_lw_acc", r_dren + r_dwen, 32'd0);
    run(1, 0, 2'b11, 0, 32'h0000_5000, 32'h0, 1, 32'h0);
    chk("err_sz3_lat", r_done_cyc, 32'd1);
    chk("err_sz3",     {r_rdata[30:0], r_err}, 32'h1);
    run(1, 1, 2'b00, 0, 32'h0000_5000, 32'h0, 1, 32'h0);
    chk("err_both",     {r_rdata[30:0], r_err}, 32'h1);
    chk("err_both_acc", r_dren + r_dwen, 32'd0);
    // Outside ERR the last load result is still visible.
    chk("rdata_hold", req_rdata, 32'h1234_ABCD);

    // Reset in the middle of an SB write
    req_wen = 1'b1; req_size = 2'b00; req_addr = 32'h0000_7002; req_wdata = 32'h77;
    @(posedge CLK); #1;
    req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    dhit = 1'b1; dload = 32'h1122_3344;
    @(posedge CLK); #1;
    dhit = 1'b0;
    chk("rst_mid_pre_dwen", {31'h0, dWEN}, 32'h1);
    chk("rst_mid_merge",    dstore, 32'h1122_7744);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_dwen", {31'h0, dWEN}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    seen_done = req_done;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (req_done) seen_done = 1'b1;
      @(posedge CLK); #1;
    end
    chk("rst_mid_no_done", {31'h0, seen_done}, 32'h0);

    // Fresh loads after reset, back-to-back
    run(1, 0, 2'b00, 1, 32'h0000_1001, 32'h0, 1, 32'h12F4_5678);
    chk("post_rst_lb",     r_rdata, 32'hFFFF_FFF4);
    chk("post_rst_lb_lat", r_done_cyc, 32'd2);
    run(1, 0, 2'b00, 0, 32'h0000_1003, 32'h0, 1, 32'h0000_0080);
    chk("b2b_lbu", r_rdata, 32'h0000_0080);
    chk("b2b_lat", r_done_cyc, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
